// File: rtl/apb_gpio_irq.sv
// ---------------------------------------------------------------------------
// apb_gpio_irq
//   APB slave GPIO controller with per-pin direction, atomic set/clear,
//   synchronised inputs, rise/fall edge interrupts (W1C status), a fixed
//   number of wait states per transfer and error responses on illegal access.
//
// Register map (byte address, word aligned):
//   0x00 DATA_IN  RO   0x04 DATA_OUT RW   0x08 OUT_SET WO   0x0C OUT_CLR WO
//   0x10 DIR      RW   0x14 RISE_EN  RW   0x18 FALL_EN RW   0x1C IRQ_STATUS RW1C
//
// Ports:
//   PCLK, PRST        clock, synchronous active-high reset
//   PSEL..PSTRB       APB requester inputs (8-bit address, 32-bit data)
//   PRDATA/PREADY/PSLVERR  APB completer outputs
//   GpioIn            asynchronous pin inputs
//   GpioOut/GpioOEn   pin output values / output enables (1 = drive)
//   Irq               OR of all IRQ_STATUS bits
//
// Build option:
//   GPIO_DEBOUNCE_EN  when defined, each input pin must hold a new value for
//                     DEBOUNCE_CYCLES consecutive cycles before DATA_IN and the
//                     edge detector see it. Undefined: no filtering.
// ---------------------------------------------------------------------------
module apb_gpio_irq #(
  parameter int GPIO_WIDTH      = 32,
  parameter int WAIT_STATES     = 0,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  PCLK,
  input  logic                  PRST,
  input  logic                  PSEL,
  input  logic                  PENABLE,
  input  logic                  PWRITE,
  input  logic [7:0]            PADDR,
  input  logic [31:0]           PWDATA,
  input  logic [3:0]            PSTRB,
  output logic [31:0]           PRDATA,
  output logic                  PREADY,
  output logic                  PSLVERR,
  input  logic [GPIO_WIDTH-1:0] GpioIn,
  output logic [GPIO_WIDTH-1:0] GpioOut,
  output logic [GPIO_WIDTH-1:0] GpioOEn,
  output logic                  Irq
);

  if (GPIO_WIDTH < 1 || GPIO_WIDTH > 32 || WAIT_STATES < 0 || WAIT_STATES > 15 ||
      DEBOUNCE_CYCLES < 1) begin : g_param_check
    $error("apb_gpio_irq: parameter out of range");
  end

  typedef enum logic {ST_IDLE, ST_ACCESS} state_t;

  state_t state_q, state_d;
  logic [3:0] wait_q, wait_d;

  logic [GPIO_WIDTH-1:0] data_out, dir, rise_en, fall_en, irq_status;
  logic [GPIO_WIDTH-1:0] sync1, sync2, filt, prev;

  // ---------------- transfer FSM ----------------
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge PCLK) begin
    if (PRST) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ST_ACCESS;
          wait_d  = 4'(WAIT_STATES);
        end
      end
      ST_ACCESS: begin
        if (!PSEL)             state_d = ST_IDLE;   // aborted: nothing commits
        else if (wait_q != '0) wait_d  = wait_q - 4'd1;
        else                   state_d = ST_IDLE;   // completion cycle
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- decode ----------------
  logic        complete, addr_err, bus_err, wr_commit;
  logic [2:0]  reg_sel;
  logic [31:0] strb_mask32, wbits32, rd_word;
  logic [GPIO_WIDTH-1:0] wmask, wbits, w1c_clr, edge_set;

  assign complete    = (state_q == ST_ACCESS) && PSEL && (wait_q == '0);
  assign addr_err    = (PADDR[1:0] != 2'b00) || (PADDR > 8'h1C);
  assign bus_err     = addr_err || (PWRITE && (PADDR == 8'h00));
  assign wr_commit   = complete && PWRITE && !bus_err;
  assign reg_sel     = PADDR[4:2];
  assign strb_mask32 = {{8{PSTRB[3]}}, {8{PSTRB[2]}}, {8{PSTRB[1]}}, {8{PSTRB[0]}}};
  assign wbits32     = PWDATA & strb_mask32;
  assign wmask       = strb_mask32[GPIO_WIDTH-1:0];
  assign wbits       = wbits32[GPIO_WIDTH-1:0];

  always_comb begin
    rd_word = '0;
    case (reg_sel)
      3'd0:    rd_word = 32'(filt);
      3'd1:    rd_word = 32'(data_out);
      3'd4:    rd_word = 32'(dir);
      3'd5:    rd_word = 32'(rise_en);
      3'd6:    rd_word = 32'(fall_en);
      3'd7:    rd_word = 32'(irq_status);
      default: rd_word = '0;                 // OUT_SET / OUT_CLR read as zero
    endcase
  end

  // Read data is driven only on a clean read completion, zero otherwise.
  assign PREADY  = complete;
  assign PSLVERR = complete && bus_err;
  assign PRDATA  = (complete && !PWRITE && !bus_err) ? rd_word : 32'd0;

  // ---------------- registers ----------------
  assign edge_set = (filt & ~prev & rise_en) | (~filt & prev & fall_en);
  assign w1c_clr  = (wr_commit && reg_sel == 3'd7) ? wbits : '0;

  always_ff @(posedge PCLK) begin
    if (PRST) begin
      data_out   <= '0;
      dir        <= '0;
      rise_en    <= '0;
      fall_en    <= '0;
      irq_status <= '0;
    end else begin
      if (wr_commit) begin
        case (reg_sel)
          3'd1:    data_out <= (data_out & ~wmask) | wbits;
          3'd2:    data_out <= data_out | wbits;
          3'd3:    data_out <= data_out & ~wbits;
          3'd4:    dir      <= (dir & ~wmask) | wbits;
          3'd5:    rise_en  <= (rise_en & ~wmask) | wbits;
          3'd6:    fall_en  <= (fall_en & ~wmask) | wbits;
          default: ;
        endcase
      end
      // Hardware set is ORed in after the clear, so a same-cycle edge wins.
      irq_status <= (irq_status & ~w1c_clr) | edge_set;
    end
  end

  // ---------------- input path ----------------
  // NOTE: synchroniser and previous-value flops are reset as well, otherwise
  // an X/stale value leaving reset could look like a pin edge.
  always_ff @(posedge PCLK) begin
    if (PRST) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= GpioIn;
      sync2 <= sync1;
      prev  <= filt;
    end
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  logic [CNT_W-1:0] db_cnt [GPIO_WIDTH];

  // Count consecutive cycles where the synced bit disagrees with the filtered
  // bit; any agreement (a glitch ending) restarts the count.
  always_ff @(posedge PCLK) begin
    if (PRST) begin
      filt <= '0;
      for (int i = 0; i < GPIO_WIDTH; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < GPIO_WIDTH; i++) begin
        if (sync2[i] != filt[i]) begin
          if (db_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            filt[i]   <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end
`else
  assign filt = sync2;
`endif

  // ---------------- outputs ----------------
  assign GpioOut = data_out;
  assign GpioOEn = dir;
  assign Irq     = |irq_status;

endmodule

// File: tb/tb_apb_gpio_irq.sv
// ---------------------------------------------------------------------------
// tb_apb_gpio_irq
//   Self-checking bench for apb_gpio_irq (GPIO_WIDTH=16, WAIT_STATES=2,
//   DEBOUNCE_CYCLES=4). Every APB transfer pushes its expected PRDATA/PSLVERR
//   onto a queue; a negedge monitor pops and compares at each completion.
//   Scenario tasks check pin outputs, Irq and timing inline.
// ---------------------------------------------------------------------------
module tb_apb_gpio_irq;

  localparam int GW = 16;
  localparam int WS = 2;
  localparam int DB = 4;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 2 + DB;   // pin change -> filtered value, in edges
`else
  localparam int LAT = 2;
`endif

  logic          PCLK, PRST, PSEL, PENABLE, PWRITE;
  logic [7:0]    PADDR;
  logic [31:0]   PWDATA, PRDATA;
  logic [3:0]    PSTRB;
  logic          PREADY, PSLVERR, Irq;
  logic [GW-1:0] GpioIn, GpioOut, GpioOEn;

  apb_gpio_irq #(.GPIO_WIDTH(GW), .WAIT_STATES(WS), .DEBOUNCE_CYCLES(DB)) dut (
    .PCLK(PCLK), .PRST(PRST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR), .GpioIn(GpioIn), .GpioOut(GpioOut),
    .GpioOEn(GpioOEn), .Irq(Irq)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int cyc = 0;
  always @(posedge PCLK) cyc++;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] rdata;
    logic        err;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;
  int  n_cmp = 0;
  int  n_bad = 0;

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge PCLK) begin
    if (!PRST) begin
      if (PSEL && PENABLE && PREADY) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected: completion at addr %h, required no completion", PADDR);
        end else begin
          mon_e = sb.pop_front();
          if (PSLVERR !== mon_e.err) begin
            n_bad++;
            $display("FAIL pslverr wr=%0b addr=%h: got %b, required %b",
                     mon_e.wr, mon_e.addr, PSLVERR, mon_e.err);
          end
          n_cmp++;
          if (PRDATA !== mon_e.rdata) begin
            n_bad++;
            $display("FAIL prdata wr=%0b addr=%h: got %h, required %h",
                     mon_e.wr, mon_e.addr, PRDATA, mon_e.rdata);
          end
        end
      end else begin
        n_cmp++;
        if (PSLVERR !== 1'b0 || PRDATA !== 32'd0) begin
          n_bad++;
          $display("FAIL idle_outputs: got PSLVERR=%b PRDATA=%h, required 0/0", PSLVERR, PRDATA);
        end
      end
    end
  end

  // All stimulus tasks start and end at #1 after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge PCLK);
    #1;
  endtask

  task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input logic [31:0] exp_rd,
                          input logic exp_err, output int lo);
    sb.push_back('{wr, addr, exp_rd, exp_err});
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata; PSTRB = strb;
    idle(1);
    PENABLE = 1'b1;
    lo = 0;
    while (!PREADY && lo < 64) begin
      idle(1);
      lo++;
    end
    n_cmp++;
    if (!PREADY) begin
      n_bad++;
      $display("FAIL pready_timeout addr=%h: PREADY still %b after %0d cycles, required 1", addr, PREADY, lo);
      void'(sb.pop_back());
    end
    idle(1);
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data,
                    input logic [3:0] strb = 4'hF, input logic err = 1'b0);
    int lo;
    apb_xfer(1'b1, addr, data, strb, 32'd0, err, lo);
  endtask

  task automatic rd(input logic [7:0] addr, input logic [31:0] exp, input logic err = 1'b0);
    int lo;
    apb_xfer(1'b0, addr, 32'd0, 4'h0, exp, err, lo);
  endtask

  task automatic test_reset;
    logic [7:0] regs [6] = '{8'h00, 8'h04, 8'h10, 8'h14, 8'h18, 8'h1C};
    n_cmp++;
    if ({PRDATA, PREADY, PSLVERR, GpioOut, GpioOEn, Irq} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: PRDATA=%h PREADY=%b PSLVERR=%b GpioOut=%h GpioOEn=%h Irq=%b, required all 0",
               PRDATA, PREADY, PSLVERR, GpioOut, GpioOEn, Irq);
    end
    PRST = 1'b0;
    idle(1);
    foreach (regs[i]) rd(regs[i], 32'd0);
  endtask

  task automatic test_wait_states;
    int lo;
    apb_xfer(1'b1, 8'h04, 32'h0001_A5A5, 4'hF, 32'd0, 1'b0, lo);
    n_cmp++;
    if (lo !== WS) begin
      n_bad++;
      $display("FAIL wait_cycles_write: PREADY low %0d cycles, required %0d", lo, WS);
    end
    n_cmp++;
    if (GpioOut !== 16'hA5A5) begin
      n_bad++;
      $display("FAIL gpioout_after_write: got %h, required a5a5", GpioOut);
    end
    apb_xfer(1'b0, 8'h04, 32'd0, 4'h0, 32'h0000_A5A5, 1'b0, lo);
    n_cmp++;
    if (lo !== WS) begin
      n_bad++;
      $display("FAIL wait_cycles_read: PREADY low %0d cycles, required %0d", lo, WS);
    end
  endtask

  task automatic test_set_clr;
    wr(8'h04, 32'h0000_00F0);
    wr(8'h08, 32'h0000_000F);
    wr(8'h0C, 32'h0000_0030);
    n_cmp++;
    if (GpioOut !== 16'h00CF) begin
      n_bad++;
      $display("FAIL set_clr: got %h, required 00cf", GpioOut);
    end
    wr(8'h04, 32'h0000_FFFF, 4'b0010);
    n_cmp++;
    if (GpioOut !== 16'hFFCF) begin
      n_bad++;
      $display("FAIL strobe_lane1: got %h, required ffcf", GpioOut);
    end
    rd(8'h08, 32'd0);
    rd(8'h0C, 32'd0);
    rd(8'h04, 32'h0000_FFCF);
  endtask

  task automatic test_dir;
    wr(8'h10, 32'h0000_1234);
    n_cmp++;
    if (GpioOEn !== 16'h1234) begin
      n_bad++;
      $display("FAIL dir_oen: got %h, required 1234", GpioOEn);
    end
    rd(8'h10, 32'h0000_1234);
  endtask

  task automatic test_errors;
    rd(8'h20, 32'd0, 1'b1);
    rd(8'h06, 32'd0, 1'b1);
    wr(8'h00, 32'h0000_FFFF, 4'hF, 1'b1);
    wr(8'h06, 32'h0000_0000, 4'hF, 1'b1);
    wr(8'h12, 32'h0000_0000, 4'hF, 1'b1);
    wr(8'h24, 32'h0000_0000, 4'hF, 1'b1);
    n_cmp++;
    if (GpioOut !== 16'hFFCF || GpioOEn !== 16'h1234) begin
      n_bad++;
      $display("FAIL err_no_change: GpioOut=%h GpioOEn=%h, required ffcf/1234", GpioOut, GpioOEn);
    end
    rd(8'h04, 32'h0000_FFCF);
    rd(8'h10, 32'h0000_1234);
  endtask

  task automatic test_abort;
    int lo;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h10; PWDATA = 32'h0000_FFFF; PSTRB = 4'hF;
    idle(1);
    PENABLE = 1'b1;
    n_cmp++;
    if (PREADY !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_pready: got %b in first ACCESS cycle, required 0", PREADY);
    end
    idle(WS);                 // would be the completion cycle; withdraw PSEL here
    PSEL = 1'b0; PENABLE = 1'b0;
    idle(1);
    n_cmp++;
    if (GpioOEn !== 16'h1234) begin
      n_bad++;
      $display("FAIL abort_dir: got %h, required 1234", GpioOEn);
    end
    apb_xfer(1'b0, 8'h10, 32'd0, 4'h0, 32'h0000_1234, 1'b0, lo);
    n_cmp++;
    if (lo !== WS) begin
      n_bad++;
      $display("FAIL abort_next_xfer: PREADY low %0d cycles, required %0d", lo, WS);
    end
  endtask

  task automatic test_back_to_back;
    int c0;
    c0 = cyc;
    wr(8'h14, 32'h0000_0005);
    rd(8'h14, 32'h0000_0005);
    wr(8'h18, 32'h0000_0003);
    rd(8'h18, 32'h0000_0003);
    n_cmp++;
    if (cyc - c0 !== 4 * (WS + 2)) begin
      n_bad++;
      $display("FAIL back_to_back_cycles: got %0d, required %0d", cyc - c0, 4 * (WS + 2));
    end
    wr(8'h14, 32'd0);
    wr(8'h18, 32'd0);
  endtask

  task automatic test_edges;
    int lo;
    int off;
    wr(8'h10, 32'h0000_0003);          // pins 0/1 driven: edges must still be seen
    GpioIn = 16'h0002;
    idle(10);
    wr(8'h14, 32'h0000_0001);
    wr(8'h18, 32'h0000_0002);
    rd(8'h1C, 32'd0);
    GpioIn = 16'h0001;                 // bit0 rises, bit1 falls
    idle(10);
    n_cmp++;
    if (Irq !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_on_edges: got %b, required 1", Irq);
    end
    rd(8'h1C, 32'h0000_0003);
    wr(8'h1C, 32'h0000_0001, 4'h0);    // no strobes: nothing cleared
    rd(8'h1C, 32'h0000_0003);
    wr(8'h1C, 32'h0000_0001);
    rd(8'h1C, 32'h0000_0002);
    wr(8'h1C, 32'h0000_0002);
    n_cmp++;
    if (Irq !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_cleared: got %b, required 0", Irq);
    end
    GpioIn[1] = 1'b1;                  // rise on bit1 is not enabled
    idle(10);
    rd(8'h1C, 32'd0);
    // Time the bit-1 fall so it reaches the detector on the W1C completion cycle.
    off = WS + 1 - LAT;
    if (off >= 0) begin
      fork
        apb_xfer(1'b1, 8'h1C, 32'h0000_0002, 4'hF, 32'd0, 1'b0, lo);
        begin
          if (off > 0) idle(off);
          GpioIn[1] = 1'b0;
        end
      join
    end else begin
      GpioIn[1] = 1'b0;
      idle(-off);
      apb_xfer(1'b1, 8'h1C, 32'h0000_0002, 4'hF, 32'd0, 1'b0, lo);
    end
    rd(8'h1C, 32'h0000_0002);
    wr(8'h14, 32'd0);
    wr(8'h18, 32'd0);
    n_cmp++;
    if (Irq !== 1'b1) begin
      n_bad++;
      $display("FAIL irq_after_enable_clear: got %b, required 1", Irq);
    end
    rd(8'h1C, 32'h0000_0002);
    wr(8'h1C, 32'h0000_0002);
    n_cmp++;
    if (Irq !== 1'b0) begin
      n_bad++;
      $display("FAIL irq_final_clear: got %b, required 0", Irq);
    end
  endtask

  task automatic test_input_latency;
    wr(8'h14, 32'h0000_0010);
    GpioIn[4] = 1'b1;
    idle(LAT);
    n_cmp++;
    if (Irq !== 1'b0) begin
      n_bad++;
      $display("FAIL latency_early: Irq=%b %0d edges after change, required 0", Irq, LAT);
    end
    idle(1);
    n_cmp++;
    if (Irq !== 1'b1) begin
      n_bad++;
      $display("FAIL latency_on_time: Irq=%b %0d edges after change, required 1", Irq, LAT + 1);
    end
    rd(8'h00, {16'h0, GpioIn});
    wr(8'h1C, 32'h0000_0010);
    wr(8'h14, 32'd0);
  endtask

`ifdef GPIO_DEBOUNCE_EN
  task automatic test_debounce;
    logic [GW-1:0] exp_in;
    wr(8'h14, 32'h0000_0004);
    GpioIn[2] = 1'b1;
    idle(3);
    GpioIn[2] = 1'b0;                  // 3-cycle glitch: must be rejected
    idle(12);
    n_cmp++;
    if (Irq !== 1'b0) begin
      n_bad++;
      $display("FAIL debounce_glitch_irq: got %b, required 0", Irq);
    end
    rd(8'h00, {16'h0, GpioIn});
    GpioIn[2] = 1'b1;
    idle(2 + DB);
    GpioIn[2] = 1'b0;                  // 6-cycle pulse
    n_cmp++;
    if (Irq !== 1'b0) begin
      n_bad++;
      $display("FAIL debounce_pulse_early: got %b, required 0", Irq);
    end
    idle(1);
    n_cmp++;
    if (Irq !== 1'b1) begin
      n_bad++;
      $display("FAIL debounce_pulse_irq: got %b, required 1", Irq);
    end
    exp_in = GpioIn | 16'h0004;        // filtered bit still high during this read
    rd(8'h00, {16'h0, exp_in});
    idle(12);
    wr(8'h1C, 32'h0000_0004);
    wr(8'h14, 32'd0);
  endtask
`endif

  task automatic test_reset_mid;
    wr(8'h14, 32'h0000_0008);
    GpioIn[3] = 1'b1;
    idle(LAT + 4);
    wr(8'h10, 32'h0000_FFFF);
    n_cmp++;
    if (Irq !== 1'b1 || GpioOEn !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL pre_reset_state: Irq=%b GpioOEn=%h, required 1/ffff", Irq, GpioOEn);
    end
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h04; PWDATA = 32'h0000_5A5A; PSTRB = 4'hF;
    idle(1);
    PENABLE = 1'b1;
    idle(1);
    PRST = 1'b1; PSEL = 1'b0; PENABLE = 1'b0;
    idle(1);
    n_cmp++;
    if ({PRDATA, PREADY, PSLVERR, GpioOut, GpioOEn, Irq} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset_outputs: PRDATA=%h PREADY=%b PSLVERR=%b GpioOut=%h GpioOEn=%h Irq=%b, required all 0",
               PRDATA, PREADY, PSLVERR, GpioOut, GpioOEn, Irq);
    end
    PRST = 1'b0;
    idle(1);
    rd(8'h04, 32'd0);
    rd(8'h10, 32'd0);
    rd(8'h14, 32'd0);
    rd(8'h1C, 32'd0);
    rd(8'h00, {16'h0, GpioIn});
  endtask

  initial begin
    PRST = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    PADDR = '0; PWDATA = '0; PSTRB = '0; GpioIn = '0;
    idle(3);
    test_reset;
    test_wait_states;
    test_set_clr;
    test_dir;
    test_errors;
    test_abort;
    test_back_to_back;
    test_edges;
    test_input_latency;
`ifdef GPIO_DEBOUNCE_EN
    test_debounce;
`endif
    test_reset_mid;
    idle(2);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: %0d expected completions never seen, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
